// File: rtl/axi_sram_slave_pkg.sv
// Shared widths, response/burst codes, one-hot FSM states and beat-address helpers
// for the AXI3 SRAM responder.
package axi_sram_slave_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_RD_ADDR = 5'b00010,
      S_RD_DATA = 5'b00100,
      S_WR_DATA = 5'b01000,
      S_WR_RESP = 5'b10000
   } state_t;

   // Transfers wider than the 32-bit bus are narrowed to a full word.
   function automatic logic [2:0] clamp_size(input logic [2:0] size);
      return (size > 3'd2) ? 3'd2 : size;
   endfunction

   // WRAP has no special handling and advances like INCR.
   function automatic logic [ADDR_W-1:0] beat_next_addr(input logic [ADDR_W-1:0] addr,
                                                        input logic [2:0]        size,
                                                        input logic [1:0]        burst);
      if (burst == BURST_FIXED) return addr;
      return addr + (32'd1 << size);
   endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between an initiator and the SRAM responder.
interface axi_sram_slave_if;
   import axi_sram_slave_pkg::*;

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [LEN_W-1:0]  arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;

   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [LEN_W-1:0]  awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;

   logic [ID_W-1:0]   wid;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;

   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

endinterface

// File: rtl/axi_sram_slave_sram_bytewe.sv
// Word-addressed SRAM: one read port with 1-cycle registered output (held when
// not enabled) and one write port with per-byte enables.
module axi_sram_slave_sram_bytewe
   import axi_sram_slave_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_re,
   input  logic [MEM_AW-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata,
   input  logic              i_we,
   input  logic [MEM_AW-1:0] i_waddr,
   input  logic [STRB_W-1:0] i_wbe,
   input  logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] r_mem [2**MEM_AW];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder over on-chip SRAM: one transaction at a time, INCR/FIXED bursts,
// whole-word reads and byte-strobed writes.
module axi_sram_slave
   import axi_sram_slave_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic            aclk,
   input  logic            areset,
   axi_sram_slave_if.slave s_axi
);

   state_t              r_state, w_state_nxt;
   logic [ID_W-1:0]     r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len, r_beat;
   logic [2:0]          r_size;
   logic [1:0]          r_burst, r_bresp;
   logic                r_rlast, r_ovf;

   logic w_arready, w_awready, w_wready, w_rvalid, w_bvalid;
   logic w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;
   logic w_sram_re, w_sram_we;
   logic [DATA_W-1:0] w_sram_q;
   logic w_unused;

   assign w_unused = ^s_axi.wid;

   always_comb begin
      w_state_nxt = r_state;
      w_arready   = 1'b0;
      w_awready   = 1'b0;
      w_wready    = 1'b0;
      w_rvalid    = 1'b0;
      w_bvalid    = 1'b0;
      if (!areset) begin
         unique case (r_state)
            S_IDLE: begin
               // A simultaneous AR wins; AW stays pending until the read is done.
               w_arready = 1'b1;
               w_awready = !s_axi.arvalid;
               if (s_axi.arvalid)      w_state_nxt = S_RD_ADDR;
               else if (s_axi.awvalid) w_state_nxt = S_WR_DATA;
            end
            S_RD_ADDR: w_state_nxt = S_RD_DATA;
            S_RD_DATA: begin
               w_rvalid = 1'b1;
               if (s_axi.rready && r_rlast) w_state_nxt = S_IDLE;
            end
            S_WR_DATA: begin
               w_wready = 1'b1;
               if (s_axi.wvalid && s_axi.wlast) w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
               w_bvalid = 1'b1;
               if (s_axi.bready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_ar_hs = s_axi.arvalid & w_arready;
   assign w_aw_hs = s_axi.awvalid & w_awready;
   assign w_r_hs  = s_axi.rready  & w_rvalid;
   assign w_w_hs  = s_axi.wvalid  & w_wready;

   // Next beat is fetched only on a handshake, so a stall leaves the SRAM output untouched.
   assign w_sram_re = (r_state == S_RD_ADDR) | (w_r_hs & ~r_rlast);
   assign w_sram_we = w_w_hs;

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_rlast <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ar_hs || w_aw_hs) begin
            r_beat  <= '0;
            r_rlast <= 1'b0;
            r_ovf   <= 1'b0;
         end else if (r_state == S_RD_ADDR) begin
            r_rlast <= (r_len == '0);
         end else if (w_r_hs) begin
            r_beat  <= r_beat + 4'd1;
            r_rlast <= (r_beat + 4'd1 == r_len);
         end else if (w_w_hs) begin
            if (&r_beat) r_ovf  <= 1'b1;
            else         r_beat <= r_beat + 4'd1;
         end
      end
   end

   // Transaction attributes and beat address.
   always_ff @(posedge aclk) begin
      if (w_ar_hs) begin
         r_id    <= s_axi.arid;
         r_addr  <= s_axi.araddr;
         r_len   <= s_axi.arlen;
         r_size  <= clamp_size(s_axi.arsize);
         r_burst <= s_axi.arburst;
      end else if (w_aw_hs) begin
         r_id    <= s_axi.awid;
         r_addr  <= s_axi.awaddr;
         r_len   <= s_axi.awlen;
         r_size  <= clamp_size(s_axi.awsize);
         r_burst <= s_axi.awburst;
      end else if (w_sram_re || w_sram_we) begin
         r_addr  <= beat_next_addr(r_addr, r_size, r_burst);
      end
      if (w_w_hs && s_axi.wlast)
         r_bresp <= (r_ovf || (r_beat != r_len)) ? RESP_SLVERR : RESP_OKAY;
   end

   axi_sram_slave_sram_bytewe #(.MEM_AW(MEM_AW)) u_sram (
      .i_clk   (aclk),
      .i_re    (w_sram_re),
      .i_raddr (r_addr[MEM_AW+1:2]),
      .o_rdata (w_sram_q),
      .i_we    (w_sram_we),
      .i_waddr (r_addr[MEM_AW+1:2]),
      .i_wbe   (s_axi.wstrb),
      .i_wdata (s_axi.wdata)
   );

   assign s_axi.arready = w_arready;
   assign s_axi.awready = w_awready;
   assign s_axi.wready  = w_wready;
   assign s_axi.rvalid  = w_rvalid;
   assign s_axi.rlast   = w_rvalid & r_rlast;
   assign s_axi.rdata   = w_rvalid ? w_sram_q : '0;
   assign s_axi.rid     = w_rvalid ? r_id : '0;
   assign s_axi.rresp   = RESP_OKAY;
   assign s_axi.bvalid  = w_bvalid;
   assign s_axi.bid     = w_bvalid ? r_id : '0;
   assign s_axi.bresp   = w_bvalid ? r_bresp : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: expected R beats and B responses are queued
// from a reference memory when requests are issued and compared as the DUT answers.
module tb_axi_sram_slave;

   logic aclk = 1'b0;
   logic areset = 1'b1;

   axi_sram_slave_if bus();

   axi_sram_slave #(.MEM_AW(10)) dut (
      .aclk   (aclk),
      .areset (areset),
      .s_axi  (bus)
   );

   always #5 aclk = ~aclk;

   typedef struct packed { logic [31:0] data; logic [3:0] id; logic last; } rexp_t;
   typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

   rexp_t       rq[$];
   bexp_t       bq[$];
   logic [31:0] model [1024];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   logic [31:0] d;
   logic [3:0]  id;
   logic        last;
   logic [1:0]  resp;
   bit          ok;
   int          at;
   rexp_t       e;
   bexp_t       be;

   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
      logic [2:0] s;
      s = (size > 3'd2) ? 3'd2 : size;
      if (burst == 2'b00) return a;
      return a + (32'd1 << s);
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb);
      for (int i = 0; i < 4; i++)
         if (strb[i]) model[a[11:2]][8*i +: 8] = wd[8*i +: 8];
   endfunction

   function automatic void push_read(input logic [3:0] rid, input logic [31:0] addr, input logic [3:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] a;
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         rq.push_back('{data: model[a[11:2]], id: rid, last: (b == int'(len))});
         a = step_addr(a, size, burst);
      end
   endfunction

   // All bus tasks start and end at a falling edge; handshake is judged 1 time unit later.
   task automatic send_ar(input logic [3:0] i, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] bu, output bit okk);
      bus.arid = i; bus.araddr = a; bus.arlen = l; bus.arsize = s; bus.arburst = bu;
      bus.arvalid = 1'b1;
      okk = 1'b0;
      for (int k = 0; k < 60 && !okk; k++) begin
         #1 okk = bus.arready;
         @(negedge aclk);
      end
      bus.arvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [3:0] i, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] bu, output bit okk);
      bus.awid = i; bus.awaddr = a; bus.awlen = l; bus.awsize = s; bus.awburst = bu;
      bus.awvalid = 1'b1;
      okk = 1'b0;
      for (int k = 0; k < 60 && !okk; k++) begin
         #1 okk = bus.awready;
         @(negedge aclk);
      end
      bus.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] wd, input logic [3:0] strb, input logic wl, output bit okk);
      bus.wdata = wd; bus.wstrb = strb; bus.wlast = wl; bus.wvalid = 1'b1;
      okk = 1'b0;
      for (int k = 0; k < 60 && !okk; k++) begin
         #1 okk = bus.wready;
         @(negedge aclk);
      end
      bus.wvalid = 1'b0;
   endtask

   task automatic recv_b(output logic [3:0] bi, output logic [1:0] br, output bit okk);
      bus.bready = 1'b1;
      okk = 1'b0; bi = 'x; br = 'x;
      for (int k = 0; k < 60 && !okk; k++) begin
         #1;
         if (bus.bvalid) begin okk = 1'b1; bi = bus.bid; br = bus.bresp; end
         @(negedge aclk);
      end
      bus.bready = 1'b0;
   endtask

   task automatic recv_r(output logic [31:0] rd, output logic [3:0] ri, output logic rl,
                         output logic [1:0] rr, output bit okk, output int stamp);
      bus.rready = 1'b1;
      okk = 1'b0; rd = 'x; ri = 'x; rl = 'x; rr = 'x; stamp = -1;
      for (int k = 0; k < 60 && !okk; k++) begin
         #1;
         if (bus.rvalid) begin
            okk = 1'b1; rd = bus.rdata; ri = bus.rid; rl = bus.rlast; rr = bus.rresp; stamp = cyc;
         end
         @(negedge aclk);
      end
      bus.rready = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge aclk);
      #1;
      checks++;
      if (bus.arready !== 1'b0 || bus.awready !== 1'b0 || bus.wready !== 1'b0 ||
          bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.bvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl got ar=%b aw=%b w=%b rv=%b rl=%b bv=%b want all 0",
                  bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast, bus.bvalid);
      end
      checks++;
      if (bus.rdata !== 32'd0 || bus.rid !== 4'd0 || bus.bid !== 4'd0 ||
          bus.rresp !== 2'd0 || bus.bresp !== 2'd0) begin
         failures++;
         $display("FAIL reset_data got rdata=%h rid=%0d bid=%0d rresp=%0d bresp=%0d want 0",
                  bus.rdata, bus.rid, bus.bid, bus.rresp, bus.bresp);
      end
      @(negedge aclk);
      areset = 1'b0;
      #1;
      checks++;
      if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release got arready=%b awready=%b want 1 1", bus.arready, bus.awready);
      end
      @(negedge aclk);
   endtask

   task automatic test_preload();
      bit wok;
      logic [31:0] base, wd;
      for (int blk = 0; blk < 2; blk++) begin
         base = 32'(blk) * 32'd64;
         send_aw(4'(blk + 1), base, 4'd15, 3'd2, 2'b01, wok);
         for (int b = 0; b < 16; b++) begin
            wd = $urandom;
            send_w(wd, 4'hF, (b == 15), ok);
            wok &= ok;
            model_write(base + 32'(4 * b), wd, 4'hF);
         end
         bq.push_back('{id: 4'(blk + 1), resp: 2'b00});
         recv_b(id, resp, ok);
         be = bq.pop_front();
         checks++;
         if (!ok || !wok || id !== be.id || resp !== be.resp) begin
            failures++;
            $display("FAIL preload_b blk=%0d got ok=%0b wok=%0b bid=%0d bresp=%0d want bid=%0d bresp=%0d",
                     blk, ok, wok, id, resp, be.id, be.resp);
         end
      end
   endtask

   task automatic test_single_read();
      send_aw(4'd1, 32'h10, 4'd0, 3'd2, 2'b01, ok);
      send_w(32'hDEADBEEF, 4'hF, 1'b1, ok);
      model_write(32'h10, 32'hDEADBEEF, 4'hF);
      recv_b(id, resp, ok);
      push_read(4'd3, 32'h10, 4'd0, 3'd2, 2'b01);
      send_ar(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, ok);
      #1;
      checks++;
      if (!ok || bus.rvalid !== 1'b0) begin
         failures++;
         $display("FAIL single_latency_t1 got ar_ok=%0b rvalid=%b want 1 0", ok, bus.rvalid);
      end
      @(negedge aclk);
      #1;
      e = rq.pop_front();
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== e.data || bus.rid !== e.id ||
          bus.rlast !== 1'b1 || bus.rresp !== 2'b00 || e.data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_read got rv=%b d=%h id=%0d last=%b resp=%0d want rv=1 d=%h id=%0d last=1 resp=0",
                  bus.rvalid, bus.rdata, bus.rid, bus.rlast, bus.rresp, e.data, e.id);
      end
      bus.rready = 1'b1;
      @(negedge aclk);
      bus.rready = 1'b0;
   endtask

   task automatic test_incr_read();
      int prev;
      prev = -1;
      push_read(4'd5, 32'h20, 4'd3, 3'd2, 2'b01);
      send_ar(4'd5, 32'h20, 4'd3, 3'd2, 2'b01, ok);
      while (rq.size() > 0) begin
         recv_r(d, id, last, resp, ok, at);
         e = rq.pop_front();
         checks++;
         if (!ok || d !== e.data || id !== e.id || last !== e.last || resp !== 2'b00 ||
             (prev >= 0 && at != prev + 1)) begin
            failures++;
            $display("FAIL incr_read got ok=%0b d=%h id=%0d last=%b resp=%0d cyc=%0d want d=%h id=%0d last=%b resp=0 cyc=%0d",
                     ok, d, id, last, resp, at, e.data, e.id, e.last, prev + 1);
         end
         prev = at;
         if (!ok) rq.delete();
      end
   endtask

   task automatic test_read_stall();
      logic [31:0] hd;
      logic [3:0]  hid;
      logic        hl, held;
      held = 1'b0; hd = '0; hid = '0; hl = 1'b0;
      push_read(4'd6, 32'h20, 4'd3, 3'd2, 2'b01);
      send_ar(4'd6, 32'h20, 4'd3, 3'd2, 2'b01, ok);
      for (int k = 0; k < 40 && rq.size() > 0; k++) begin
         bus.rready = ((k % 2) == 0);
         #1;
         if (bus.rvalid) begin
            if (held) begin
               checks++;
               if (bus.rdata !== hd || bus.rid !== hid || bus.rlast !== hl) begin
                  failures++;
                  $display("FAIL stall_hold got d=%h id=%0d last=%b want d=%h id=%0d last=%b",
                           bus.rdata, bus.rid, bus.rlast, hd, hid, hl);
               end
            end
            held = !bus.rready;
            hd = bus.rdata; hid = bus.rid; hl = bus.rlast;
            if (bus.rready) begin
               e = rq.pop_front();
               checks++;
               if (bus.rdata !== e.data || bus.rid !== e.id || bus.rlast !== e.last) begin
                  failures++;
                  $display("FAIL stall_beat got d=%h id=%0d last=%b want d=%h id=%0d last=%b",
                           bus.rdata, bus.rid, bus.rlast, e.data, e.id, e.last);
               end
            end
         end
         @(negedge aclk);
      end
      bus.rready = 1'b0;
      checks++;
      if (rq.size() != 0) begin
         failures++;
         $display("FAIL stall_drain got %0d beats left want 0", rq.size());
         rq.delete();
      end
   endtask

   task automatic test_fixed_and_size();
      push_read(4'd2, 32'h08, 4'd2, 3'd2, 2'b00);
      send_ar(4'd2, 32'h08, 4'd2, 3'd2, 2'b00, ok);
      push_read(4'd4, 32'h30, 4'd1, 3'd3, 2'b01);
      while (rq.size() > 2) begin
         recv_r(d, id, last, resp, ok, at);
         e = rq.pop_front();
         checks++;
         if (!ok || d !== e.data || id !== e.id || last !== e.last) begin
            failures++;
            $display("FAIL fixed_read got ok=%0b d=%h id=%0d last=%b want d=%h id=%0d last=%b",
                     ok, d, id, last, e.data, e.id, e.last);
         end
      end
      send_ar(4'd4, 32'h30, 4'd1, 3'd3, 2'b01, ok);
      while (rq.size() > 0) begin
         recv_r(d, id, last, resp, ok, at);
         e = rq.pop_front();
         checks++;
         if (!ok || d !== e.data || id !== e.id || last !== e.last) begin
            failures++;
            $display("FAIL size_clamp got ok=%0b d=%h id=%0d last=%b want d=%h id=%0d last=%b",
                     ok, d, id, last, e.data, e.id, e.last);
         end
         if (!ok) rq.delete();
      end
   endtask

   task automatic test_byte_write();
      send_aw(4'd8, 32'h41, 4'd0, 3'd0, 2'b01, ok);
      send_w(32'h0000AB00, 4'b0010, 1'b1, ok);
      model_write(32'h41, 32'h0000AB00, 4'b0010);
      bq.push_back('{id: 4'd8, resp: 2'b00});
      recv_b(id, resp, ok);
      be = bq.pop_front();
      checks++;
      if (!ok || id !== be.id || resp !== be.resp) begin
         failures++;
         $display("FAIL byte_write_b got ok=%0b bid=%0d bresp=%0d want bid=%0d bresp=%0d",
                  ok, id, resp, be.id, be.resp);
      end
      push_read(4'd9, 32'h40, 4'd0, 3'd2, 2'b01);
      send_ar(4'd9, 32'h40, 4'd0, 3'd2, 2'b01, ok);
      recv_r(d, id, last, resp, ok, at);
      e = rq.pop_front();
      checks++;
      if (!ok || d !== e.data || d[15:8] !== 8'hAB || id !== e.id) begin
         failures++;
         $display("FAIL byte_readback got ok=%0b d=%h id=%0d want d=%h id=%0d", ok, d, id, e.data, e.id);
      end
   endtask

   task automatic test_tie();
      push_read(4'd5, 32'h24, 4'd0, 3'd2, 2'b01);
      bus.arid = 4'd5; bus.araddr = 32'h24; bus.arlen = 4'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
      bus.awid = 4'd9; bus.awaddr = 32'h60; bus.awlen = 4'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
      bus.arvalid = 1'b1;
      bus.awvalid = 1'b1;
      #1;
      checks++;
      if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
         failures++;
         $display("FAIL tie_ready got arready=%b awready=%b want 1 0", bus.arready, bus.awready);
      end
      @(negedge aclk);
      bus.arvalid = 1'b0;
      #1;
      checks++;
      if (bus.awready !== 1'b0) begin
         failures++;
         $display("FAIL tie_aw_wait got awready=%b want 0", bus.awready);
      end
      @(negedge aclk);
      recv_r(d, id, last, resp, ok, at);
      e = rq.pop_front();
      checks++;
      if (!ok || d !== e.data || id !== e.id || last !== 1'b1) begin
         failures++;
         $display("FAIL tie_read got ok=%0b d=%h id=%0d last=%b want d=%h id=%0d last=1",
                  ok, d, id, last, e.data, e.id);
      end
      send_aw(4'd9, 32'h60, 4'd0, 3'd2, 2'b01, ok);
      send_w(32'h600DF00D, 4'hF, 1'b1, ok);
      model_write(32'h60, 32'h600DF00D, 4'hF);
      bq.push_back('{id: 4'd9, resp: 2'b00});
      recv_b(id, resp, ok);
      be = bq.pop_front();
      checks++;
      if (!ok || id !== be.id || resp !== be.resp) begin
         failures++;
         $display("FAIL tie_b got ok=%0b bid=%0d bresp=%0d want bid=%0d bresp=%0d", ok, id, resp, be.id, be.resp);
      end
   endtask

   task automatic test_wlast();
      send_aw(4'd6, 32'h80, 4'd1, 3'd2, 2'b01, ok);
      send_w(32'h11111111, 4'hF, 1'b1, ok);
      model_write(32'h80, 32'h11111111, 4'hF);
      bq.push_back('{id: 4'd6, resp: 2'b10});
      recv_b(id, resp, ok);
      be = bq.pop_front();
      checks++;
      if (!ok || id !== be.id || resp !== be.resp) begin
         failures++;
         $display("FAIL wlast_early got ok=%0b bid=%0d bresp=%0d want bid=%0d bresp=%0d", ok, id, resp, be.id, be.resp);
      end
      send_aw(4'd7, 32'h90, 4'd0, 3'd2, 2'b01, ok);
      send_w(32'h22222222, 4'hF, 1'b0, ok);
      send_w(32'h33333333, 4'hF, 1'b1, ok);
      model_write(32'h90, 32'h22222222, 4'hF);
      model_write(32'h94, 32'h33333333, 4'hF);
      bq.push_back('{id: 4'd7, resp: 2'b10});
      recv_b(id, resp, ok);
      be = bq.pop_front();
      checks++;
      if (!ok || id !== be.id || resp !== be.resp) begin
         failures++;
         $display("FAIL wlast_late got ok=%0b bid=%0d bresp=%0d want bid=%0d bresp=%0d", ok, id, resp, be.id, be.resp);
      end
      push_read(4'd1, 32'h90, 4'd1, 3'd2, 2'b01);
      send_ar(4'd1, 32'h90, 4'd1, 3'd2, 2'b01, ok);
      while (rq.size() > 0) begin
         recv_r(d, id, last, resp, ok, at);
         e = rq.pop_front();
         checks++;
         if (!ok || d !== e.data || last !== e.last) begin
            failures++;
            $display("FAIL wlast_readback got ok=%0b d=%h last=%b want d=%h last=%b", ok, d, last, e.data, e.last);
         end
         if (!ok) rq.delete();
      end
   endtask

   task automatic test_reset_mid();
      push_read(4'd2, 32'h0, 4'd7, 3'd2, 2'b01);
      send_ar(4'd2, 32'h0, 4'd7, 3'd2, 2'b01, ok);
      for (int b = 0; b < 3; b++) begin
         recv_r(d, id, last, resp, ok, at);
         e = rq.pop_front();
         checks++;
         if (!ok || d !== e.data || last !== 1'b0) begin
            failures++;
            $display("FAIL mid_beat%0d got ok=%0b d=%h last=%b want d=%h last=0", b, ok, d, last, e.data);
         end
      end
      rq.delete();
      bus.rready = 1'b1;
      areset = 1'b1;
      @(negedge aclk);
      #1;
      checks++;
      if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got rvalid=%b arready=%b want 0 0", bus.rvalid, bus.arready);
      end
      @(negedge aclk);
      areset = 1'b0;
      bus.rready = 1'b0;
      @(negedge aclk);
      #1;
      checks++;
      if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
         failures++;
         $display("FAIL mid_release got rvalid=%b arready=%b want 0 1", bus.rvalid, bus.arready);
      end
      @(negedge aclk);
      push_read(4'd3, 32'h0, 4'd7, 3'd2, 2'b01);
      send_ar(4'd3, 32'h0, 4'd7, 3'd2, 2'b01, ok);
      while (rq.size() > 0) begin
         recv_r(d, id, last, resp, ok, at);
         e = rq.pop_front();
         checks++;
         if (!ok || d !== e.data || id !== e.id || last !== e.last) begin
            failures++;
            $display("FAIL mid_readback got ok=%0b d=%h id=%0d last=%b want d=%h id=%0d last=%b",
                     ok, d, id, last, e.data, e.id, e.last);
         end
         if (!ok) rq.delete();
      end
   endtask

   initial begin
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.rready = 1'b0; bus.bready = 1'b0;

      test_reset();
      test_preload();
      test_single_read();
      test_incr_read();
      test_read_stall();
      test_fixed_and_size();
      test_byte_write();
      test_tie();
      test_wlast();
      test_reset_mid();

      checks++;
      if (rq.size() != 0 || bq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty got r=%0d b=%0d want 0 0", rq.size(), bq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
